dmem_responder: RTL and testbench

//   Data-memory responder for the CPU load/store path. Accepts one request at a time over a

---
 rtl/dmem_pkg.sv | 24 ++
 rtl/dmem_lane_align.sv | 52 +++++
 rtl/dmem_responder.sv | 141 ++++++++++++++
 tb/tb_dmem_responder.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } dmem_size_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_RESP = 2'b10
    } dmem_state_e;

    localparam int WAIT_CNT_W = 4;

    // Saturating increment for the statistics counters.
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane steering: store byte enables/data, load shift/extend, error flag.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  dmem_size_e  size,
    input  logic [1:0]  addr_lo,
    input  logic        is_unsigned,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  be,
    output logic [31:0] wdata_sh,
    output logic [31:0] rdata,
    output logic        err
);

    logic [15:0] shifted;

    always_comb begin
        err      = 1'b0;
        be       = 4'b0000;
        wdata_sh = wdata;
        rdata    = '0;
        shifted  = 16'(rword >> {addr_lo, 3'b000});
        case (size)
            SZ_BYTE: begin
                be       = 4'b0001 << addr_lo;
                wdata_sh = {4{wdata[7:0]}};
                rdata    = is_unsigned ? {24'b0, shifted[7:0]}
                                       : {{24{shifted[7]}}, shifted[7:0]};
            end
            SZ_HALF: begin
                err      = addr_lo[0];
                be       = 4'b0011 << addr_lo;
                wdata_sh = {2{wdata[15:0]}};
                rdata    = is_unsigned ? {16'b0, shifted}
                                       : {{16{shifted[15]}}, shifted};
            end
            SZ_WORD: begin
                err   = (addr_lo != 2'b00);
                be    = 4'b1111;
                rdata = rword;
            end
            default: err = 1'b1;
        endcase
        // Errored accesses never touch the RAM and return zero.
        if (err) begin
            be    = 4'b0000;
            rdata = '0;
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: request handshake, WAIT_STATES latency, response handshake.
// Optional DMEM_STATS_EN adds saturating load/store/error response counters.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH_LOG2  = 10,
    parameter int WAIT_STATES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [DATA_WIDTH-1:0] req_addr,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err
`ifdef DMEM_STATS_EN
    ,
    output logic [31:0]           stat_loads,
    output logic [31:0]           stat_stores,
    output logic [31:0]           stat_errs
`endif
);

    localparam int LANES = DATA_WIDTH / 8;
    localparam int DEPTH = 1 << DEPTH_LOG2;

    dmem_state_e           state_reg, state_next;
    logic [WAIT_CNT_W-1:0] cnt_reg;
    logic [DEPTH_LOG2-1:0] idx_reg;
    logic [1:0]            lo_reg;
    logic                  we_reg, uns_reg;
    dmem_size_e            size_reg;
    logic [DATA_WIDTH-1:0] wdata_reg, rd_word_reg;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic                  accept, access, rsp_fire;
    logic [LANES-1:0]      be;
    logic [DATA_WIDTH-1:0] wdata_sh, rdata_al;
    logic                  err;

    // Upper address bits alias onto the same RAM words by design.
    logic unused_addr;
    assign unused_addr = ^{req_addr[DATA_WIDTH-1:DEPTH_LOG2+2]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= ST_IDLE;
        else        state_reg <= state_next;
    end

    // WAIT is always visited so the response appears WAIT_STATES+1 cycles after accept.
    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        access     = 1'b0;
        rsp_fire   = 1'b0;
        case (state_reg)
            ST_IDLE: if (req_valid) begin
                accept     = 1'b1;
                state_next = ST_WAIT;
            end
            ST_WAIT: if (cnt_reg == '0) begin
                access     = 1'b1;
                state_next = ST_RESP;
            end
            ST_RESP: if (rsp_ready) begin
                rsp_fire   = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
        req_ready = (state_reg == ST_IDLE);
        rsp_valid = (state_reg == ST_RESP);
        rsp_rdata = (rsp_valid && !we_reg) ? rdata_al : '0;
        rsp_err   = rsp_valid && err;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg   <= '0;
            idx_reg   <= '0;
            lo_reg    <= '0;
            we_reg    <= 1'b0;
            uns_reg   <= 1'b0;
            size_reg  <= SZ_BYTE;
            wdata_reg <= '0;
        end else if (accept) begin
            cnt_reg   <= WAIT_CNT_W'(WAIT_STATES);
            idx_reg   <= req_addr[DEPTH_LOG2+1:2];
            lo_reg    <= req_addr[1:0];
            we_reg    <= req_we;
            uns_reg   <= req_unsigned;
            size_reg  <= dmem_size_e'(req_size);
            wdata_reg <= req_wdata;
        end else if (state_reg == ST_WAIT && cnt_reg != '0) begin
            cnt_reg <= cnt_reg - 1'b1;
        end
    end

    // Word RAM with per-lane write enables and registered read, not reset.
    always_ff @(posedge clk) begin
        if (access) begin
            for (int i = 0; i < LANES; i++) begin
                if (we_reg && be[i]) mem[idx_reg][8*i +: 8] <= wdata_sh[8*i +: 8];
            end
            rd_word_reg <= mem[idx_reg];
        end
    end

    dmem_lane_align u_align (
        .size        (size_reg),
        .addr_lo     (lo_reg),
        .is_unsigned (uns_reg),
        .wdata       (wdata_reg),
        .rword       (rd_word_reg),
        .be          (be),
        .wdata_sh    (wdata_sh),
        .rdata       (rdata_al),
        .err         (err)
    );

`ifdef DMEM_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_loads  <= '0;
            stat_stores <= '0;
            stat_errs   <= '0;
        end else if (rsp_fire) begin
            if (err)         stat_errs   <= sat_inc(stat_errs);
            else if (we_reg) stat_stores <= sat_inc(stat_stores);
            else             stat_loads  <= sat_inc(stat_loads);
        end
    end
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Directed table-driven bench for dmem_responder (WAIT_STATES=2 main, WAIT_STATES=0 latency copy).
module tb_dmem_responder;

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    localparam int NV = 18;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0, req_we = 1'b0, req_unsigned = 1'b0, rsp_ready = 1'b1;
    logic [1:0]  req_size = 2'b00;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic        req_ready, rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic        v0 = 1'b0, rr0 = 1'b1;
    logic        req_ready0, rsp_valid0, rsp_err0;
    logic [31:0] rsp_rdata0;
`ifdef DMEM_STATS_EN
    logic [31:0] stat_loads, stat_stores, stat_errs;
    logic [31:0] stat_loads0, stat_stores0, stat_errs0;
`endif

    int   total = 0, passed = 0;
    vec_t vecs[NV];

    always #5 clk = ~clk;

    dmem_responder #(.DATA_WIDTH(32), .DEPTH_LOG2(10), .WAIT_STATES(2)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_we(req_we), .req_size(req_size),
        .req_unsigned(req_unsigned), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
`ifdef DMEM_STATS_EN
        , .stat_loads(stat_loads), .stat_stores(stat_stores), .stat_errs(stat_errs)
`endif
    );

    dmem_responder #(.DATA_WIDTH(32), .DEPTH_LOG2(10), .WAIT_STATES(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .req_valid(v0), .req_ready(req_ready0),
        .req_addr(req_addr), .req_we(req_we), .req_size(req_size),
        .req_unsigned(req_unsigned), .req_wdata(req_wdata), .rsp_valid(rsp_valid0),
        .rsp_ready(rr0), .rsp_rdata(rsp_rdata0), .rsp_err(rsp_err0)
`ifdef DMEM_STATS_EN
        , .stat_loads(stat_loads0), .stat_stores(stat_stores0), .stat_errs(stat_errs0)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    function automatic vec_t mk(input logic we, input logic [1:0] sz, input logic uns,
                                input logic [31:0] addr, input logic [31:0] wd,
                                input logic [31:0] er, input logic ee);
        vec_t v;
        v.we = we; v.size = sz; v.uns = uns; v.addr = addr; v.wdata = wd;
        v.exp_rdata = er; v.exp_err = ee;
        return v;
    endfunction

    // One full request/response transaction on the main instance.
    task automatic do_req(input vec_t v, output logic [31:0] rd, output logic er);
        int n;
        rd = '0;
        er = 1'b0;
        @(negedge clk);
        req_we = v.we; req_size = v.size; req_unsigned = v.uns;
        req_addr = v.addr; req_wdata = v.wdata; req_valid = 1'b1; rsp_ready = 1'b1;
        n = 0;
        while (!req_ready && n < 20) begin @(negedge clk); n++; end
        if (n >= 20) chk("accept_timeout", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        n = 0;
        while (!rsp_valid && n < 40) begin @(negedge clk); n++; end
        if (n >= 40) chk("rsp_timeout", 32'(rsp_valid), 32'd1);
        rd = rsp_rdata;
        er = rsp_err;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          e_loads, e_stores, e_errs, n;

        vecs[0]  = mk(1, 2'b10, 0, 32'h10,   32'hDEADBEEF, 32'h0,        0);
        vecs[1]  = mk(0, 2'b10, 0, 32'h10,   32'h0,        32'hDEADBEEF, 0);
        vecs[2]  = mk(1, 2'b00, 0, 32'h11,   32'h00000080, 32'h0,        0);
        vecs[3]  = mk(0, 2'b10, 0, 32'h10,   32'h0,        32'hDEAD80EF, 0);
        vecs[4]  = mk(0, 2'b00, 0, 32'h11,   32'h0,        32'hFFFFFF80, 0);
        vecs[5]  = mk(0, 2'b00, 1, 32'h11,   32'h0,        32'h00000080, 0);
        vecs[6]  = mk(0, 2'b01, 0, 32'h13,   32'h0,        32'h0,        1);
        vecs[7]  = mk(1, 2'b10, 0, 32'h12,   32'h12345678, 32'h0,        1);
        vecs[8]  = mk(0, 2'b10, 0, 32'h10,   32'h0,        32'hDEAD80EF, 0);
        vecs[9]  = mk(0, 2'b11, 0, 32'h10,   32'h0,        32'h0,        1);
        vecs[10] = mk(0, 2'b01, 0, 32'h12,   32'h0,        32'hFFFFDEAD, 0);
        vecs[11] = mk(0, 2'b01, 1, 32'h10,   32'h0,        32'h000080EF, 0);
        vecs[12] = mk(1, 2'b10, 0, 32'h14,   32'h0,        32'h0,        0);
        vecs[13] = mk(1, 2'b01, 0, 32'h16,   32'h1234A5C3, 32'h0,        0);
        vecs[14] = mk(0, 2'b10, 0, 32'h1014, 32'h0,        32'hA5C30000, 0);
        vecs[15] = mk(0, 2'b00, 0, 32'h17,   32'h0,        32'hFFFFFFA5, 0);
        vecs[16] = mk(1, 2'b00, 0, 32'h13,   32'h0000007F, 32'h0,        0);
        vecs[17] = mk(0, 2'b00, 0, 32'h13,   32'h0,        32'h0000007F, 0);

        // Reset state
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_req_ready", 32'(req_ready), 32'd1);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_rsp_rdata", rsp_rdata, 32'd0);
        chk("reset_rsp_err",   32'(rsp_err), 32'd0);

        e_loads = 0; e_stores = 0; e_errs = 0;
        for (int i = 0; i < NV; i++) begin
            do_req(vecs[i], rd, er);
            $display("vec%0d we=%0b size=%0b uns=%0b addr=0x%08h wdata=0x%08h -> rdata=0x%08h err=%0b",
                     i, vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].wdata, rd, er);
            chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
            chk($sformatf("vec%0d_err", i), 32'(er), 32'(vecs[i].exp_err));
            if (vecs[i].exp_err) e_errs++;
            else if (vecs[i].we) e_stores++;
            else e_loads++;
        end
`ifdef DMEM_STATS_EN
        chk("stat_loads",  stat_loads,  32'(e_loads));
        chk("stat_stores", stat_stores, 32'(e_stores));
        chk("stat_errs",   stat_errs,   32'(e_errs));
`endif

        // Latency, stall and response/request collision on WAIT_STATES=2
        @(negedge clk);
        req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0; req_addr = 32'h10;
        req_valid = 1'b1; rsp_ready = 1'b0;
        chk("lat_ready_before", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1 begin req_size = 2'b00; req_unsigned = 1'b1; end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("lat_valid_edge%0d", k), 32'(rsp_valid), (k == 3) ? 32'd1 : 32'd0);
            chk($sformatf("lat_ready_edge%0d", k), 32'(req_ready), 32'd0);
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("stall%0d_valid", k), 32'(rsp_valid), 32'd1);
            chk($sformatf("stall%0d_rdata", k), rsp_rdata, 32'h7FAD80EF);
            chk($sformatf("stall%0d_ready", k), 32'(req_ready), 32'd0);
        end
        $display("latency/stall sequence rdata=0x%08h", rsp_rdata);
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("collide_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("collide_req_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        chk("collide_accepted", 32'(req_ready), 32'd0);
        req_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 40) begin @(negedge clk); n++; end
        if (n >= 40) chk("collide_timeout", 32'(rsp_valid), 32'd1);
        chk("collide_rdata", rsp_rdata, 32'h000000EF);
        chk("collide_err", 32'(rsp_err), 32'd0);
        $display("collision follow-up load rdata=0x%08h err=%0b", rsp_rdata, rsp_err);
        @(posedge clk);

        // WAIT_STATES=0 instance: response after edge N+1
        @(negedge clk);
        req_we = 1'b0; req_size = 2'b11; req_addr = 32'h0; v0 = 1'b1; rr0 = 1'b0;
        @(posedge clk);
        #1 v0 = 1'b0;
        @(negedge clk);
        chk("ws0_valid_edgeN", 32'(rsp_valid0), 32'd0);
        @(negedge clk);
        chk("ws0_valid_edgeN1", 32'(rsp_valid0), 32'd1);
        chk("ws0_err", 32'(rsp_err0), 32'd1);
        chk("ws0_rdata", rsp_rdata0, 32'd0);
        $display("ws0 illegal-size response valid=%0b err=%0b", rsp_valid0, rsp_err0);
        rr0 = 1'b1;
        @(negedge clk);
        chk("ws0_done", 32'(rsp_valid0), 32'd0);

        // Reset during WAIT of a store drops it
        do_req(mk(1, 2'b10, 0, 32'h20, 32'h11111111, 32'h0, 0), rd, er);
        @(negedge clk);
        req_we = 1'b1; req_size = 2'b10; req_addr = 32'h20; req_wdata = 32'h22222222;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
`ifdef DMEM_STATS_EN
        chk("rst_stat_loads",  stat_loads,  32'd0);
        chk("rst_stat_stores", stat_stores, 32'd0);
        chk("rst_stat_errs",   stat_errs,   32'd0);
`endif
        do_req(mk(0, 2'b10, 0, 32'h20, 32'h0, 32'h0, 0), rd, er);
        $display("post-reset load @0x20 rdata=0x%08h err=%0b", rd, er);
        chk("rst_prior_value", rd, 32'h11111111);
        chk("rst_prior_err", 32'(er), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", passed, total);
        $fatal(1);
    end

endmodule
